fraction_reducer: RTL and testbench

- Sequential reducer that takes an unsigned fraction num/den and returns it in lowest terms, plus the greatest common factor it used.
- Iterative and multi-cycle: binary GCD loop followed by two parallel restoring dividers.
- Sits downstream of the arithmetic helpers (overflow, factor, factorial stages) and feeds rational-result consumers.
- Valid/ready on both sides, so it can be dropped into a pipeline with backpressure.

---
 rtl/fraction_reducer.sv | 149 ++++++++++++++
 tb/tb_fraction_reducer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fraction_reducer.sv
// Reduces an unsigned fraction num/den to lowest terms using a binary GCD loop
// followed by two parallel restoring dividers; valid/ready on both sides.
module fraction_reducer #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] num,
    input  logic [N-1:0] den,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] num_out,
    output logic [N-1:0] den_out,
    output logic [N-1:0] gcf_out,
    output logic         err
);

    localparam int unsigned KW = $clog2(N) + 1;
    localparam logic [KW-1:0] LastCnt = KW'(N - 1);

    typedef enum logic [1:0] {StIdle, StGcd, StDiv, StDone} state_t;

    state_t        state;
    logic [N-1:0]  num_l, den_l;
    logic [N-1:0]  a, b, gcf;
    logic [KW-1:0] k;
    logic [KW-1:0] cnt;
    logic [N-1:0]  rem_n, rem_d;
    logic [N-1:0]  quo_n, quo_d;

    // Restoring step: shift the next dividend bit into the partial remainder.
    logic [N:0]   trial_n, trial_d;
    logic         ge_n, ge_d;
    logic [N-1:0] rem_n_nxt, rem_d_nxt;

    always_comb begin
        trial_n   = {rem_n, quo_n[N-1]};
        trial_d   = {rem_d, quo_d[N-1]};
        ge_n      = trial_n >= {1'b0, gcf};
        ge_d      = trial_d >= {1'b0, gcf};
        // Only taken when trial >= gcf, so the difference fits in N bits.
        rem_n_nxt = trial_n[N-1:0] - gcf;
        rem_d_nxt = trial_d[N-1:0] - gcf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            num_out   <= '0;
            den_out   <= '0;
            gcf_out   <= '0;
            err       <= 1'b0;
            num_l     <= '0;
            den_l     <= '0;
            a         <= '0;
            b         <= '0;
            gcf       <= '0;
            k         <= '0;
            cnt       <= '0;
            rem_n     <= '0;
            rem_d     <= '0;
            quo_n     <= '0;
            quo_d     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        num_l    <= num;
                        den_l    <= den;
                        a        <= num;
                        b        <= den;
                        k        <= '0;
                        if (den == '0) begin
                            state     <= StDone;
                            out_valid <= 1'b1;
                            err       <= 1'b1;
                            num_out   <= num;
                            den_out   <= '0;
                            gcf_out   <= '0;
                        end else if (num == '0) begin
                            state     <= StDone;
                            out_valid <= 1'b1;
                            err       <= 1'b0;
                            num_out   <= '0;
                            den_out   <= N'(1);
                            gcf_out   <= den;
                        end else begin
                            state <= StGcd;
                        end
                    end
                end
                StGcd: begin
                    if (a == b) begin
                        gcf   <= a << k;
                        rem_n <= '0;
                        rem_d <= '0;
                        quo_n <= num_l;
                        quo_d <= den_l;
                        cnt   <= '0;
                        state <= StDiv;
                    end else if (!a[0] && !b[0]) begin
                        a <= a >> 1;
                        b <= b >> 1;
                        k <= k + 1'b1;
                    end else if (!a[0]) begin
                        a <= a >> 1;
                    end else if (!b[0]) begin
                        b <= b >> 1;
                    end else if (a > b) begin
                        a <= a - b;
                    end else begin
                        b <= b - a;
                    end
                end
                StDiv: begin
                    // Dividend bits leave at the top while quotient bits enter at the bottom.
                    rem_n <= ge_n ? rem_n_nxt : trial_n[N-1:0];
                    rem_d <= ge_d ? rem_d_nxt : trial_d[N-1:0];
                    quo_n <= {quo_n[N-2:0], ge_n};
                    quo_d <= {quo_d[N-2:0], ge_d};
                    cnt   <= cnt + 1'b1;
                    if (cnt == LastCnt) begin
                        state     <= StDone;
                        out_valid <= 1'b1;
                        err       <= 1'b0;
                        num_out   <= {quo_n[N-2:0], ge_n};
                        den_out   <= {quo_d[N-2:0], ge_d};
                        gcf_out   <= gcf;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fraction_reducer.sv
// Scoreboard bench for fraction_reducer: the driver queues expected results,
// a negedge monitor compares them whenever out_valid is high.
module tb_fraction_reducer;

    localparam int unsigned N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] num = '0;
    logic [N-1:0] den = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] num_out, den_out, gcf_out;
    logic         err;

    fraction_reducer #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .num      (num),
        .den      (den),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .num_out  (num_out),
        .den_out  (den_out),
        .gcf_out  (gcf_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] n, d, on, od, og;
        logic         oe;
        int           lat;
    } exp_t;

    exp_t   exp_q[$];
    longint acc_q[$];
    int     total = 0;
    int     bad = 0;
    logic   prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned gcd(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Latency counts the accept edge as cycle 1.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h/%0h want none at %0t",
                             num_out, den_out, $time);
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    if (!prev_valid && e.lat >= 0 && acc_q.size() > 0)
                        chk("latency", 32'(($time - 5 - acc_q[0]) / 10 + 1), e.lat);
                    chk("num_out", num_out, e.on);
                    chk("den_out", den_out, e.od);
                    chk("gcf_out", gcf_out, e.og);
                    chk("err", err, e.oe);
                    if (out_ready) begin
                        if (!e.oe) begin
                            chk("num_product", 32'(num_out) * 32'(gcf_out), e.n);
                            chk("den_product", 32'(den_out) * 32'(gcf_out), e.d);
                            chk("coprime", gcd(num_out, den_out), 1);
                        end
                        void'(exp_q.pop_front());
                        if (acc_q.size() > 0) void'(acc_q.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [N-1:0] n, input logic [N-1:0] d, input logic [N-1:0] en,
                        input logic [N-1:0] ed, input logic [N-1:0] eg, input logic ee,
                        input int el);
        bit got = 0;
        exp_q.push_back('{n: n, d: d, on: en, od: ed, og: eg, oe: ee, lat: el});
        @(negedge clk);
        in_valid = 1'b1;
        num = n;
        den = d;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk);
                acc_q.push_back($time);
                got = 1;
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
        if (!got) begin
            chk("accept_timeout", 0, 1);
            void'(exp_q.pop_back());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run(input logic [N-1:0] n, input logic [N-1:0] d, input logic [N-1:0] en,
                       input logic [N-1:0] ed, input logic [N-1:0] eg, input logic ee,
                       input int el);
        send(n, d, en, ed, eg, ee, el);
        drain();
    endtask

    initial begin
        #1000000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned rn, rd, g;
        bit seen;

        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {num_out, den_out, gcf_out}, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("in_ready_after_release", in_ready, 1);

        // Directed vectors; latencies worked out by hand from the Stein steps
        run(16'd12, 16'd18, 16'd2, 16'd3, 16'd6, 1'b0, 5 + 1 + 16);
        run(16'd7, 16'd13, 16'd7, 16'd13, 16'd1, 1'b0, 8 + 1 + 16);
        run(16'hFFFF, 16'hFFFF, 16'd1, 16'd1, 16'hFFFF, 1'b0, 1 + 1 + 16);
        run(16'd0, 16'd5, 16'd0, 16'd1, 16'd5, 1'b0, 1);
        run(16'd5, 16'd0, 16'd5, 16'd0, 16'd0, 1'b1, 1);

        // Backpressure: hold out_ready low, poke in_valid during the stall
        out_ready = 1'b0;
        send(16'd48, 16'd64, 16'd3, 16'd4, 16'd16, 1'b0, 9 + 1 + 16);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("stall_valid_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            num = 16'd100 + 16'(i);
            den = 16'd7;
            chk("stall_in_ready", in_ready, 0);
            @(negedge clk);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        drain();
        repeat (30) @(negedge clk);

        // Reset mid-GCD: the aborted job must leave nothing behind
        @(negedge clk);
        in_valid = 1'b1;
        num = 16'd1000;
        den = 16'd250;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            seen = in_ready;
            @(posedge clk);
        end
        chk("abort_accept", seen, 1);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_outputs", {num_out, den_out, gcf_out}, 0);
        chk("abort_in_ready", in_ready, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(16'd9, 16'd6, 16'd3, 16'd2, 16'd3, 1'b0, 4 + 1 + 16);

        // Random nonzero pairs against a Euclid reference
        for (int i = 0; i < 1000; i++) begin
            if (i % 2 == 0) begin
                rn = $urandom_range(1, 65535);
                rd = $urandom_range(1, 65535);
            end else begin
                g  = $urandom_range(1, 255);
                rn = $urandom_range(1, 255) * g;
                rd = $urandom_range(1, 255) * g;
            end
            g = gcd(rn, rd);
            run(N'(rn), N'(rd), N'(rn / g), N'(rd / g), N'(g), 1'b0, -1);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
